// File: rtl/lfsr_checker_if.sv
// -----------------------------------------------------------------------------
// lfsr_checker_if
//   Bundles the sample input and checker status signals of lfsr_checker.
//   Clock and reset stay plain ports on the module.
//
//   Signals
//     i_valid    producer -> checker  i_num holds a new sample this cycle
//     i_num      producer -> checker  received 8-bit pattern word
//     i_clr      producer -> checker  synchronous clear of o_err_cnt
//     o_locked   checker -> producer  high while the checker is LOCKED
//     o_err      checker -> producer  one-cycle pulse per mismatch in LOCKED
//     o_err_cnt  checker -> producer  saturating mismatch count (ERR_W bits)
//     o_expect   checker -> producer  predicted value of the next sample
//     o_state    checker -> producer  0=IDLE 1=SEARCH 2=LOCKED
//
//   Modports
//     master  drives the sample side, observes status
//     slave   the checker itself
// -----------------------------------------------------------------------------
interface lfsr_checker_if #(
  parameter int ERR_W = 16
);
  logic             i_valid;
  logic [7:0]       i_num;
  logic             i_clr;
  logic             o_locked;
  logic             o_err;
  logic [ERR_W-1:0] o_err_cnt;
  logic [7:0]       o_expect;
  logic [1:0]       o_state;

  modport master (
    output i_valid, i_num, i_clr,
    input  o_locked, o_err, o_err_cnt, o_expect, o_state
  );

  modport slave (
    input  i_valid, i_num, i_clr,
    output o_locked, o_err, o_err_cnt, o_expect, o_state
  );
endinterface

// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
//   Receive-side self-checker for the 8-bit LFSR pattern shifter
//   (x' = {x[4]^x[3]^x[2]^x[0], x[7:1]}). Seeds a prediction from a sample,
//   locks after LOCK_CNT consecutive correct predictions, then pulses and
//   counts mismatches. LOSS_CNT consecutive mismatches drop lock to IDLE.
//
//   Ports
//     i_clk    in  clock, all state on posedge
//     i_rst_n  in  asynchronous active-low reset
//     bus      lfsr_checker_if.slave (i_valid, i_num, i_clr in;
//              o_locked, o_err, o_err_cnt, o_expect, o_state out)
//
//   Parameters
//     LOCK_CNT  consecutive correct predictions in SEARCH to lock (>=1)
//     LOSS_CNT  consecutive mismatches in LOCKED to lose lock (>=1)
//     ERR_W     error counter width; must match the interface ERR_W
//
//   Build option
//     LFSR_CHK_EDGE_EN  when defined, i_valid is ignored and a sample is
//       taken whenever i_num differs from its registered copy (one extra
//       cycle of latency). Undefined: samples are cycles with i_valid=1.
// -----------------------------------------------------------------------------
module lfsr_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input logic          i_clk,
  input logic          i_rst_n,
  lfsr_checker_if.slave bus
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [7:0] nxt(input logic [7:0] x);
    return {x[4] ^ x[3] ^ x[2] ^ x[0], x[7:1]};
  endfunction

  state_t           state_q, state_d;
  logic [7:0]       expect_q, expect_d;
  logic [MW-1:0]    match_q, match_d, match_inc;
  logic [LW-1:0]    miss_q, miss_d, miss_inc;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic             bump;

  // Sample strobe and data seen by the state machine.
  logic             smp_vld;
  logic [7:0]       smp_num;

`ifdef LFSR_CHK_EDGE_EN
  // A change of i_num against last cycle's copy is a new sample. Strobe and
  // word are registered together so the state machine sees a clean pair.
  logic [7:0] num_q;
  logic       smp_vld_q;
  logic [7:0] smp_num_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      num_q     <= 8'h00;
      smp_vld_q <= 1'b0;
      smp_num_q <= 8'h00;
    end else begin
      num_q     <= bus.i_num;
      smp_vld_q <= (bus.i_num != num_q);
      smp_num_q <= bus.i_num;
    end
  end

  assign smp_vld = smp_vld_q;
  assign smp_num = smp_num_q;
`else
  assign smp_vld = bus.i_valid;
  assign smp_num = bus.i_num;
`endif

  assign match_inc = match_q + MW'(1);
  assign miss_inc  = miss_q + LW'(1);

  always_comb begin
    state_d  = state_q;
    expect_d = expect_q;
    match_d  = match_q;
    miss_d   = miss_q;
    err_d    = 1'b0;
    bump     = 1'b0;

    if (smp_vld) begin
      unique case (state_q)
        IDLE: begin
          // 0x00 is the LFSR fixed point and can never seed a prediction.
          if (smp_num != 8'h00) begin
            expect_d = nxt(smp_num);
            match_d  = '0;
            state_d  = SEARCH;
          end
        end
        SEARCH: begin
          if (smp_num == 8'h00) begin
            state_d  = IDLE;
            expect_d = 8'h00;
            match_d  = '0;
          end else if (smp_num == expect_q) begin
            expect_d = nxt(smp_num);
            if (match_inc == MW'(LOCK_CNT)) begin
              state_d = LOCKED;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_inc;
            end
          end else begin
            // Wrong but plausible word: restart the search from it.
            expect_d = nxt(smp_num);
            match_d  = '0;
          end
        end
        LOCKED: begin
          if (smp_num == expect_q) begin
            expect_d = nxt(smp_num);
            miss_d   = '0;
          end else begin
            err_d    = 1'b1;
            bump     = 1'b1;
            // Flywheel on our own prediction rather than trusting bad data.
            expect_d = nxt(expect_q);
            if (miss_inc == LW'(LOSS_CNT)) begin
              state_d  = IDLE;
              expect_d = 8'h00;
              match_d  = '0;
              miss_d   = '0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: begin
          state_d  = IDLE;
          expect_d = 8'h00;
          match_d  = '0;
          miss_d   = '0;
        end
      endcase
    end

    // Clear has priority over a same-cycle increment; counter saturates.
    cnt_d = cnt_q;
    if (bus.i_clr) begin
      cnt_d = '0;
    end else if (bump && (cnt_q != '1)) begin
      cnt_d = cnt_q + ERR_W'(1);
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      expect_q <= 8'h00;
      match_q  <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      expect_q <= expect_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.o_state   = state_q;
  assign bus.o_expect  = expect_q;
  assign bus.o_locked  = locked_q;
  assign bus.o_err     = err_q;
  assign bus.o_err_cnt = cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_checker
//   Self-checking bench for lfsr_checker. A vector table drives the main
//   instance (ERR_W=16); expected results go into a queue when a vector is
//   driven and are popped after the clock edge that consumes it. A second
//   instance with ERR_W=2 covers counter saturation, and a hand sequence
//   covers the asynchronous reset while locked. With LFSR_CHK_EDGE_EN
//   defined, the edge-strobe lock sequence is run instead.
// -----------------------------------------------------------------------------
module tb_lfsr_checker;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lfsr_checker_if #(.ERR_W(16)) bus ();
  lfsr_checker_if #(.ERR_W(2))  bus2 ();

  lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(2)) dut2 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus2)
  );

  typedef struct {
    logic [1:0]  st;
    logic [7:0]  ex;
    logic        lk;
    logic        er;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic       v;
    logic [7:0] n;
    logic       c;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic logic [7:0] nxt(input logic [7:0] x);
    return {x[4] ^ x[3] ^ x[2] ^ x[0], x[7:1]};
  endfunction

  function automatic vec_t mk(input logic v, input logic [7:0] n, input logic c,
                              input logic [1:0] st, input logic [7:0] ex,
                              input logic lk, input logic er, input logic [15:0] cnt);
    vec_t t;
    t.v = v; t.n = n; t.c = c;
    t.e.st = st; t.e.ex = ex; t.e.lk = lk; t.e.er = er; t.e.cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) $display("FAIL %s: got %0h, required %0h", name, act, req);
    else n_pass++;
  endtask

  task automatic cmp_exp(input string tag, input exp_t e);
    chk({tag, ".state"},  32'(bus.o_state),   32'(e.st));
    chk({tag, ".expect"}, 32'(bus.o_expect),  32'(e.ex));
    chk({tag, ".locked"}, 32'(bus.o_locked),  32'(e.lk));
    chk({tag, ".err"},    32'(bus.o_err),     32'(e.er));
    chk({tag, ".errcnt"}, 32'(bus.o_err_cnt), 32'(e.cnt));
  endtask

  // Drive one vector at posedge+1, consume it at the next posedge, compare at +1.
  task automatic step(input vec_t t, input int idx);
    exp_t e;
    bus.i_valid = t.v;
    bus.i_num   = t.n;
    bus.i_clr   = t.c;
    sb.push_back(t.e);
    @(posedge clk); #1;
    e = sb.pop_front();
    $display("vec %0d: v=%0b num=%02h clr=%0b -> state=%0d expect=%02h locked=%0b err=%0b cnt=%0d",
             idx, t.v, t.n, t.c, bus.o_state, bus.o_expect, bus.o_locked, bus.o_err, bus.o_err_cnt);
    cmp_exp($sformatf("v%0d", idx), e);
  endtask

  task automatic step2(input logic v, input logic [7:0] n);
    bus2.i_valid = v;
    bus2.i_num   = n;
    @(posedge clk); #1;
    $display("sat: v=%0b num=%02h -> state=%0d locked=%0b err=%0b cnt=%0d",
             v, n, bus2.o_state, bus2.o_locked, bus2.o_err, bus2.o_err_cnt);
  endtask

`ifdef LFSR_CHK_EDGE_EN
  vec_t tbl[5];
`else
  vec_t tbl[26];
`endif

  initial begin
    bus.i_valid  = 1'b0; bus.i_num  = 8'h00; bus.i_clr  = 1'b0;
    bus2.i_valid = 1'b0; bus2.i_num = 8'h00; bus2.i_clr = 1'b0;

`ifdef LFSR_CHK_EDGE_EN
    // Each word held 7 cycles with i_valid low; state settles on the 2nd edge.
    tbl[0] = mk(0, 8'h01, 0, 2'd1, 8'h80, 0, 0, 0);
    tbl[1] = mk(0, 8'h80, 0, 2'd1, 8'h40, 0, 0, 0);
    tbl[2] = mk(0, 8'h40, 0, 2'd1, 8'h20, 0, 0, 0);
    tbl[3] = mk(0, 8'h20, 0, 2'd1, 8'h10, 0, 0, 0);
    tbl[4] = mk(0, 8'h10, 0, 2'd2, 8'h88, 1, 0, 0);
`else
    tbl[0]  = mk(1, 8'h00, 0, 2'd0, 8'h00, 0, 0, 0);  // zero in IDLE ignored
    tbl[1]  = mk(1, 8'h01, 0, 2'd1, 8'h80, 0, 0, 0);
    tbl[2]  = mk(0, 8'h33, 0, 2'd1, 8'h80, 0, 0, 0);  // no valid: hold
    tbl[3]  = mk(1, 8'h80, 0, 2'd1, 8'h40, 0, 0, 0);
    tbl[4]  = mk(1, 8'h40, 0, 2'd1, 8'h20, 0, 0, 0);
    tbl[5]  = mk(1, 8'h20, 0, 2'd1, 8'h10, 0, 0, 0);
    tbl[6]  = mk(1, 8'h10, 0, 2'd2, 8'h88, 1, 0, 0);  // 4th match locks
    tbl[7]  = mk(1, 8'h55, 0, 2'd2, 8'hC4, 1, 1, 1);  // single error, flywheel
    tbl[8]  = mk(0, 8'h55, 0, 2'd2, 8'hC4, 1, 0, 1);  // pulse is one cycle
    tbl[9]  = mk(1, 8'hC4, 0, 2'd2, 8'hE2, 1, 0, 1);
    tbl[10] = mk(1, 8'h55, 0, 2'd2, 8'h71, 1, 1, 2);
    tbl[11] = mk(1, 8'h55, 0, 2'd2, 8'h38, 1, 1, 3);
    tbl[12] = mk(1, 8'h55, 0, 2'd0, 8'h00, 0, 1, 4);  // 3rd miss loses lock
    tbl[13] = mk(0, 8'h55, 0, 2'd0, 8'h00, 0, 0, 4);
    tbl[14] = mk(1, 8'h03, 0, 2'd1, 8'h81, 0, 0, 4);
    tbl[15] = mk(1, 8'h07, 0, 2'd1, 8'h03, 0, 0, 4);  // reseed, no error
    tbl[16] = mk(1, 8'h00, 0, 2'd0, 8'h00, 0, 0, 4);  // zero in SEARCH -> IDLE
    tbl[17] = mk(0, 8'h00, 1, 2'd0, 8'h00, 0, 0, 0);  // clear
    tbl[18] = mk(1, 8'h01, 0, 2'd1, 8'h80, 0, 0, 0);
    tbl[19] = mk(1, 8'h80, 0, 2'd1, 8'h40, 0, 0, 0);
    tbl[20] = mk(1, 8'h40, 0, 2'd1, 8'h20, 0, 0, 0);
    tbl[21] = mk(1, 8'h20, 0, 2'd1, 8'h10, 0, 0, 0);
    tbl[22] = mk(1, 8'h10, 0, 2'd2, 8'h88, 1, 0, 0);
    tbl[23] = mk(1, 8'h55, 1, 2'd2, 8'hC4, 1, 1, 0);  // clear beats increment
    tbl[24] = mk(1, 8'hC4, 0, 2'd2, 8'hE2, 1, 0, 0);
    tbl[25] = mk(0, 8'h00, 0, 2'd2, 8'hE2, 1, 0, 0);
`endif

    // Reset state, checked while reset is still asserted.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.state",  32'(bus.o_state),   32'd0);
    chk("rst.expect", 32'(bus.o_expect),  32'h00);
    chk("rst.locked", 32'(bus.o_locked),  32'd0);
    chk("rst.errcnt", 32'(bus.o_err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef LFSR_CHK_EDGE_EN
    begin
      logic [1:0] prev_st;
      for (int i = 0; i < 5; i++) begin
        prev_st     = bus.o_state;
        bus.i_valid = 1'b0;
        bus.i_num   = tbl[i].n;
        bus.i_clr   = 1'b0;
        sb.push_back(tbl[i].e);
        @(posedge clk); #1;
        chk($sformatf("edge%0d.lag", i), 32'(bus.o_state), 32'(prev_st));
        @(posedge clk); #1;
        $display("edge word %02h: state=%0d expect=%02h locked=%0b",
                 tbl[i].n, bus.o_state, bus.o_expect, bus.o_locked);
        cmp_exp($sformatf("edge%0d", i), sb.pop_front());
        repeat (5) @(posedge clk);
        #1;
        chk($sformatf("edge%0d.held", i), 32'(bus.o_expect), 32'(tbl[i].e.ex));
      end
    end
`else
    for (int i = 0; i < 26; i++) step(tbl[i], i);

    // Saturation on the 2-bit counter: five errors, lock never lost.
    begin
      logic [7:0] e;
      int         nerr;
      logic [7:0] seq[5];
      logic       bad[7];
      seq[0] = 8'h01; seq[1] = 8'h80; seq[2] = 8'h40; seq[3] = 8'h20; seq[4] = 8'h10;
      for (int i = 0; i < 5; i++) step2(1'b1, seq[i]);
      chk("sat.locked", 32'(bus2.o_locked), 32'd1);
      bad[0] = 1; bad[1] = 1; bad[2] = 0; bad[3] = 1; bad[4] = 1; bad[5] = 0; bad[6] = 1;
      e    = 8'h88;
      nerr = 0;
      for (int i = 0; i < 7; i++) begin
        if (bad[i]) begin
          step2(1'b1, e ^ 8'hFF);
          nerr++;
          chk($sformatf("sat%0d.err", i), 32'(bus2.o_err), 32'd1);
          chk($sformatf("sat%0d.cnt", i), 32'(bus2.o_err_cnt), (nerr > 3) ? 32'd3 : 32'(nerr));
        end else begin
          step2(1'b1, e);
          chk($sformatf("sat%0d.err", i), 32'(bus2.o_err), 32'd0);
        end
        e = nxt(e);
      end
      chk("sat.still_locked", 32'(bus2.o_locked), 32'd1);
      step2(1'b0, 8'h00);
    end

    // Asynchronous reset while locked: outputs drop before the next edge.
    chk("arst.pre_locked", 32'(bus.o_locked), 32'd1);
    rst_n = 1'b0;
    #2;
    $display("async reset at %0t: state=%0d locked=%0b expect=%02h cnt=%0d",
             $time, bus.o_state, bus.o_locked, bus.o_expect, bus.o_err_cnt);
    chk("arst.locked",  32'(bus.o_locked),   32'd0);
    chk("arst.state",   32'(bus.o_state),    32'd0);
    chk("arst.expect",  32'(bus.o_expect),   32'h00);
    chk("arst.cnt2",    32'(bus2.o_err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(mk(1, 8'h01, 0, 2'd1, 8'h80, 0, 0, 0), 100);
`endif

    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard: %0d entries left, required 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
